// File: rtl/card_auth_arbiter.sv
// Two-requester arbiter in front of one shared card validator.
// Owner selection alternates on ties, with per-requester re-arm on REQ release.
module card_auth_arbiter #(
    parameter int TIMEOUT_CYC = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] REQ,
    input  logic [2:0] COST_A,
    input  logic [2:0] COST_B,
    input  logic       AUTH_OK,
    input  logic       AUTH_FAIL,
    output logic       AUTH_REQ,
    output logic [2:0] AUTH_COST,
    output logic [1:0] GRANT,
    output logic [1:0] VALID_TRAN,
    output logic [1:0] FAILED_TRAN,
    output logic       BUSY
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state,     w_state_nxt;
    logic          r_owner,     w_owner_nxt;
    logic          r_last,      w_last_nxt;
    logic [1:0]    r_armed,     w_armed_nxt;
    logic [TW-1:0] r_timer,     w_timer_nxt;
    logic          r_auth_req,  w_auth_req_nxt;
    logic [2:0]    r_auth_cost, w_auth_cost_nxt;
    logic [1:0]    r_grant,     w_grant_nxt;
    logic [1:0]    r_valid,     w_valid_nxt;
    logic [1:0]    r_failed,    w_failed_nxt;

    logic [1:0]    w_elig;
    logic          w_win;
    logic [1:0]    w_win_oh;
    logic [2:0]    w_win_cost;
    logic [1:0]    w_owner_oh;

    // Winner selection and next-state / next-output computation
    always_comb begin
        w_state_nxt     = r_state;
        w_owner_nxt     = r_owner;
        w_last_nxt      = r_last;
        w_armed_nxt     = r_armed | ~REQ;
        w_timer_nxt     = r_timer;
        w_auth_req_nxt  = r_auth_req;
        w_auth_cost_nxt = r_auth_cost;
        w_grant_nxt     = r_grant;
        w_valid_nxt     = 2'b00;
        w_failed_nxt    = 2'b00;

        w_elig = REQ & r_armed;
        // r_last is 1 when B was served last, so a tie goes to the other side
        if (w_elig == 2'b11) begin
            w_win = ~r_last;
        end else begin
            w_win = w_elig[1];
        end
        w_win_oh   = w_win   ? 2'b10 : 2'b01;
        w_win_cost = w_win   ? COST_B : COST_A;
        w_owner_oh = r_owner ? 2'b10 : 2'b01;

        case (r_state)
            S_IDLE: begin
                if (w_elig != 2'b00) begin
                    w_armed_nxt = w_armed_nxt & ~w_win_oh;
                    if (w_win_cost == 3'd0) begin
                        w_failed_nxt = w_win_oh;
                    end else begin
                        w_state_nxt     = S_WAIT;
                        w_owner_nxt     = w_win;
                        w_auth_req_nxt  = 1'b1;
                        w_auth_cost_nxt = w_win_cost;
                        w_grant_nxt     = w_win_oh;
                        w_timer_nxt     = '0;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (AUTH_FAIL || AUTH_OK || !REQ[r_owner] || (r_timer == TIMER_LAST)) begin
                    w_state_nxt     = S_DONE;
                    w_auth_req_nxt  = 1'b0;
                    w_auth_cost_nxt = 3'd0;
                    w_grant_nxt     = 2'b00;
                    // a response wins over an abort in the same cycle
                    if (AUTH_FAIL) begin
                        w_failed_nxt = w_owner_oh;
                    end else if (AUTH_OK) begin
                        w_valid_nxt = w_owner_oh;
                    end else if (REQ[r_owner]) begin
                        w_failed_nxt = w_owner_oh;
                    end else begin
                        w_failed_nxt = 2'b00;
                    end
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            S_DONE: begin
                w_last_nxt  = r_owner;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_auth_req_nxt  = 1'b0;
                w_auth_cost_nxt = 3'd0;
                w_grant_nxt     = 2'b00;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_owner     <= 1'b0;
            r_last      <= 1'b1;
            r_armed     <= 2'b00;
            r_timer     <= '0;
            r_auth_req  <= 1'b0;
            r_auth_cost <= 3'd0;
            r_grant     <= 2'b00;
            r_valid     <= 2'b00;
            r_failed    <= 2'b00;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_last      <= w_last_nxt;
            r_armed     <= w_armed_nxt;
            r_timer     <= w_timer_nxt;
            r_auth_req  <= w_auth_req_nxt;
            r_auth_cost <= w_auth_cost_nxt;
            r_grant     <= w_grant_nxt;
            r_valid     <= w_valid_nxt;
            r_failed    <= w_failed_nxt;
        end
    end

    assign AUTH_REQ    = r_auth_req;
    assign AUTH_COST   = r_auth_cost;
    assign GRANT       = r_grant;
    assign VALID_TRAN  = r_valid;
    assign FAILED_TRAN = r_failed;
    assign BUSY        = (r_state != S_IDLE);

endmodule

// File: doc/card_auth_arbiter.md
CARD_AUTH_ARBITER -- requirements
Module: card_auth_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 8, number of consecutive WAIT cycles without validator response before forced failure.
REQ-002 CLK  input  1  single clock; all state updates on posedge CLK.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 REQ  input  2  per-requester authorization request (bit 0 = machine A, bit 1 = machine B), level, held until transaction ends.
REQ-005 COST_A  input  3  item cost from machine A, valid while REQ[0]=1.
REQ-006 COST_B  input  3  item cost from machine B, valid while REQ[1]=1.
REQ-007 AUTH_OK  input  1  shared card validator: approval pulse.
REQ-008 AUTH_FAIL  input  1  shared card validator: decline pulse.
REQ-009 AUTH_REQ  output  1  registered request to the shared validator.
REQ-010 AUTH_COST  output  3  registered cost presented to the validator, stable while AUTH_REQ=1.
REQ-011 GRANT  output  2  registered one-hot owner of the validator; 2'b00 when idle.
REQ-012 VALID_TRAN  output  2  registered one-cycle approval pulse to the owning requester.
REQ-013 FAILED_TRAN  output  2  registered one-cycle failure pulse to the owning or rejected requester.
REQ-014 BUSY  output  1  high in any state other than IDLE.

Function
REQ-015 States SHALL be IDLE, WAIT, DONE; encoding is implementation choice, one-hot outputs only.
REQ-016 A requester SHALL be eligible only when REQ[i]=1 and its ARMED[i] bit is set; ARMED[i] sets on any cycle with REQ[i]=0 and clears when that requester is granted or rejected.
REQ-017 IDLE, one eligible requester: grant it; both eligible: grant the one not in LAST (last-served pointer); no eligible requester: stay IDLE.
REQ-018 Grant with winner cost 0: no validator request; FAILED_TRAN[winner] pulse next cycle, ARMED[winner] cleared, state stays IDLE, LAST unchanged.
REQ-019 Grant with cost 1-7: next cycle GRANT=winner, AUTH_REQ=1, AUTH_COST=winner cost (latched, ignores later COST changes), TIMER=0, state WAIT.
REQ-020 WAIT: AUTH_OK=1 and AUTH_FAIL=0 -> VALID_TRAN[owner] pulse next cycle, go DONE.
REQ-021 WAIT: AUTH_FAIL=1 (regardless of AUTH_OK) -> FAILED_TRAN[owner] pulse next cycle, go DONE.
REQ-022 WAIT: no response and REQ[owner]=0 (abort) -> go DONE, no pulse; a response in the same cycle as abort SHALL be honoured per REQ-020/021.
REQ-023 WAIT: no response, no abort -> TIMER increments; on the TIMEOUT_CYC-th such cycle -> FAILED_TRAN[owner] pulse next cycle, go DONE.
REQ-024 TIMER SHALL be wide enough for TIMEOUT_CYC and SHALL not wrap; it resets to 0 on every WAIT entry.
REQ-025 DONE lasts exactly one cycle: AUTH_REQ=0, GRANT=00, LAST=owner, then IDLE; validator inputs in DONE/IDLE are ignored.
REQ-026 Latency: REQ sampled in IDLE to AUTH_REQ high = 1 cycle; validator response to VALID/FAILED pulse = 1 cycle; min back-to-back grant spacing = 3 cycles.
REQ-027 VALID_TRAN and FAILED_TRAN SHALL never both be high, and never for more than one cycle per transaction.
REQ-028 A requester still holding REQ after its transaction SHALL not be re-granted until REQ drops for at least one cycle.

Reset
REQ-029 RESET=1 at posedge: state IDLE, AUTH_REQ=0, AUTH_COST=0, GRANT=00, VALID_TRAN=00, FAILED_TRAN=00, BUSY=0, TIMER=0, LAST=B (so A wins the first tie), ARMED=00.
REQ-030 RESET during WAIT SHALL abandon the transaction with no VALID/FAILED pulse; RESET overrides every other input.

Verification
REQ-031 A alone, COST_A=3, AUTH_OK on 3rd WAIT cycle -> AUTH_COST=3, GRANT=01, VALID_TRAN=01 one cycle, BUSY low 1 cycle after DONE.
REQ-032 REQ=11 after reset, then held -> A served first, B next; with REQ re-armed both, A's next grant only after B: strict alternation.
REQ-033 B granted, no response 8 cycles -> FAILED_TRAN=10 exactly once on cycle 9 after AUTH_REQ rose; AUTH_REQ low next cycle.
REQ-034 AUTH_OK and AUTH_FAIL same cycle -> FAILED_TRAN pulse only; COST_A=0 request -> FAILED_TRAN=01 with AUTH_REQ never high.
REQ-035 A drops REQ in WAIT with no response -> no pulse, DONE then IDLE; A holding REQ after completion -> no regrant until REQ low one cycle.
REQ-036 RESET asserted mid-WAIT -> next cycle all outputs zero, no pulses, state IDLE.
